// File: rtl/sec_word_encoder.sv
// sec_word_encoder: SEC check-bit generator for 32-bit words, feeding the
// matching single-error-correcting decoder.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : input word handshake (in_data, in_chk_en)
//   out_valid/out_ready      : codeword handshake (out_data, out_chk, out_chk_en)
//   word_cnt / clr_cnt       : saturating accepted-word counter, sync clear
// Optional feature: define ECC_ERR_INJECT_EN to add inj_arm, inj_idx,
// inj_sticky and inj_done for single-bit fault injection into codewords.
module sec_word_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ECC_ERR_INJECT_EN
  input  logic             inj_arm,
  input  logic [5:0]       inj_idx,
  input  logic             inj_sticky,
  output logic             inj_done,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_chk_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_chk,
  output logic             out_chk_en,
  output logic [CNT_W-1:0] word_cnt,
  input  logic             clr_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned ENT_W  = DATA_W + CHK_W + 1;

  // Buffer entry; bit order matches the codeword index (data 0..31, check 32..39).
  typedef struct packed {
    logic              chk_en;
    logic [CHK_W-1:0]  chk;
    logic [DATA_W-1:0] data;
  } cw_t;

  // c[3:0] = byte parities; c[7:4] = XOR of (bit position within byte + 1).
  function automatic logic [CHK_W-1:0] f_check(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    logic [3:0]       pos;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      pos = 4'(i % 8) + 4'd1;
      if (d[5'(i)]) begin
        c[3'(i / 8)] = ~c[3'(i / 8)];
        c[7:4]       = c[7:4] ^ pos;
      end
    end
    return c;
  endfunction

  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  cw_t              r_head;
  cw_t              r_skid;
  cw_t              w_head_nxt;
  cw_t              w_skid_nxt;
  cw_t              w_clean;
  cw_t              w_new;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] r_cnt;

  assign w_push  = in_valid & r_in_ready;
  assign w_pop   = r_out_valid & out_ready;
  assign w_clean = '{chk_en: in_chk_en, chk: f_check(in_data), data: in_data};

`ifdef ECC_ERR_INJECT_EN
  logic             r_armed;
  logic             r_inj_done;
  logic             w_inj;
  logic [ENT_W-1:0] w_flip;

  // Out-of-range indices consume the arm but flip nothing.
  assign w_inj  = r_armed & w_push & (inj_idx < 6'd40);
  assign w_flip = w_inj ? (ENT_W'(1) << inj_idx) : '0;
  assign w_new  = cw_t'(w_clean ^ w_flip);

  // Arm pulse wins over consumption so a re-arm on the accept cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_inj_done <= 1'b0;
    end else begin
      r_inj_done <= w_inj;
      if (inj_arm) begin
        r_armed <= 1'b1;
      end else if (w_push && !inj_sticky) begin
        r_armed <= 1'b0;
      end
    end
  end

  assign inj_done = r_inj_done;
`else
  assign w_new = w_clean;
`endif

  // Head register drives the outputs; skid holds the second word under stall.
  always_comb begin
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    w_count_nxt = r_count;
    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_head_nxt  = w_new;
          w_count_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_head_nxt = w_new;
        end else if (w_push) begin
          w_skid_nxt  = w_new;
          w_count_nxt = 2'd2;
        end else if (w_pop) begin
          w_count_nxt = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low when full, so only a pop can happen here.
        if (w_pop) begin
          w_head_nxt  = r_skid;
          w_count_nxt = 2'd1;
        end
      end
      default: w_count_nxt = 2'd0;
    endcase
  end

  // Buffer state; handshake flags registered from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      r_head      <= w_head_nxt;
      r_skid      <= w_skid_nxt;
    end
  end

  // Saturating accepted-word counter; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_push && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_head.data;
  assign out_chk    = r_head.chk;
  assign out_chk_en = r_head.chk_en;
  assign word_cnt   = r_cnt;

endmodule

// File: tb/tb_sec_word_encoder.sv
// Bench for sec_word_encoder: queue-based model, per-cycle compare,
// directed literal vectors plus randomized traffic. Second instance uses CNT_W=4.
module tb_sec_word_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_chk_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready, out_valid, out_chk_en;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic [15:0] word_cnt;
  logic        in_ready4, out_valid4, out_chk_en4;
  logic [31:0] out_data4;
  logic [7:0]  out_chk4;
  logic [3:0]  word_cnt4;

`ifdef ECC_ERR_INJECT_EN
  logic        inj_arm = 1'b0;
  logic [5:0]  inj_idx = '0;
  logic        inj_sticky = 1'b0;
  logic        inj_done, inj_done4;
`endif

  always #5 clk = ~clk;

  sec_word_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ECC_ERR_INJECT_EN
    .inj_arm(inj_arm), .inj_idx(inj_idx), .inj_sticky(inj_sticky), .inj_done(inj_done),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk_en(in_chk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chk(out_chk),
    .out_chk_en(out_chk_en), .word_cnt(word_cnt), .clr_cnt(clr_cnt)
  );

  sec_word_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef ECC_ERR_INJECT_EN
    .inj_arm(inj_arm), .inj_idx(inj_idx), .inj_sticky(inj_sticky), .inj_done(inj_done4),
`endif
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_chk_en(in_chk_en),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_chk(out_chk4),
    .out_chk_en(out_chk_en4), .word_cnt(word_cnt4), .clr_cnt(clr_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
    logic        en;
    logic [31:0] orig;
  } ent_t;

  ent_t q[$];
  ent_t last;
  ent_t m_e;
  ent_t m_h;
  int   mcnt = 0;
  int   mcnt4 = 0;
  bit   armed = 1'b0;
  bit   exp_done = 1'b0;
  bit   m_acc, m_pop;
  int   m_sz;
  int   total = 0;
  int   bad = 0;

  // Check bits straight from the rule: byte parity, then (i mod 8)+1 bit groups.
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    int p;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        c[i / 8] = ~c[i / 8];
        p = (i % 8) + 1;
        for (int j = 0; j < 4; j++) begin
          if (((p >> j) & 1) == 1) c[4 + j] = ~c[4 + j];
        end
      end
    end
    return c;
  endfunction

  // Reference SEC decoder: match the syndrome against each data bit's column.
  function automatic logic [31:0] decode(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s;
    logic [31:0] r;
    logic [31:0] one;
    s = ref_chk(d) ^ c;
    r = d;
    if (s != 8'h00) begin
      for (int i = 0; i < 32; i++) begin
        one = 32'h1 << i;
        if (ref_chk(one) == s) r[i] = ~r[i];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of expected codewords, updated on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last.data = '0; last.chk = '0; last.en = 1'b0; last.orig = '0;
      mcnt = 0; mcnt4 = 0; armed = 1'b0; exp_done = 1'b0;
    end else begin
      m_sz  = q.size();
      m_acc = in_valid && (m_sz < 2);
      m_pop = (m_sz > 0) && out_ready;
      exp_done = 1'b0;
      if (m_pop) begin
        last = q[0];
        void'(q.pop_front());
      end
      if (m_acc) begin
        m_e.data = in_data;
        m_e.orig = in_data;
        m_e.chk  = ref_chk(in_data);
        m_e.en   = in_chk_en;
`ifdef ECC_ERR_INJECT_EN
        if (armed) begin
          if (inj_idx < 40) begin
            if (inj_idx < 32) m_e.data[inj_idx] = ~m_e.data[inj_idx];
            else m_e.chk[inj_idx - 32] = ~m_e.chk[inj_idx - 32];
            exp_done = 1'b1;
          end
          if (!inj_sticky) armed = 1'b0;
        end
`endif
        q.push_back(m_e);
      end
`ifdef ECC_ERR_INJECT_EN
      if (inj_arm) armed = 1'b1;
`endif
      if (clr_cnt) begin
        mcnt = 0; mcnt4 = 0;
      end else if (m_acc) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) m_h = q[0];
      else m_h = last;
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("out_data", 64'(out_data), 64'(m_h.data));
      check("out_chk", 64'(out_chk), 64'(m_h.chk));
      check("out_chk_en", 64'(out_chk_en), 64'(m_h.en));
      check("word_cnt", 64'(word_cnt), 64'(mcnt));
      check("word_cnt4", 64'(word_cnt4), 64'(mcnt4));
      if (out_valid) check("decoded", 64'(decode(out_data, out_chk)), 64'(m_h.orig));
`ifdef ECC_ERR_INJECT_EN
      check("inj_done", 64'(inj_done), 64'(exp_done));
`endif
    end
  end

  // Present one word and hold it until accepted; returns 2 time units after the accept edge.
  task automatic drive(input logic [31:0] d, input logic en);
    bit ok;
    logic rdy;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_chk_en = en;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept want accept at %0t", $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] vec_d[4] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [7:0]  vec_c[4] = '{8'h11, 8'h88, 8'h00, 8'h00};

  initial begin
    last.data = '0; last.chk = '0; last.en = 1'b0; last.orig = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    step();

    // Encoding vectors, one cycle latency from an empty buffer
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      drive(vec_d[v], 1'b1);
      @(negedge clk);
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_chk", 64'(out_chk), 64'(vec_c[v]));
      step();
    end

    // Backpressure: two words fill the buffer, the third waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0001; in_chk_en = 1'b1;
    step();
    in_data = 32'hA5A5_0002; in_chk_en = 1'b0;
    step();
    in_data = 32'hA5A5_0003; in_chk_en = 1'b1;
    @(negedge clk);
    check("bp_full", 64'(in_ready), 64'd0);
    check("bp_head", 64'(out_data), 64'hA5A5_0001);
    step();
    @(negedge clk);
    check("bp_stable", 64'(out_data), 64'hA5A5_0001);
    step();
    out_ready = 1'b1;
    drive(32'hA5A5_0003, 1'b1);
    repeat (4) step();

    // Streaming 100 words back to back
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      in_data = $urandom;
      in_chk_en = 1'($urandom % 2);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_cnt", 64'(word_cnt), 64'd100);
    check("sat_cnt4", 64'(word_cnt4), 64'd15);
    step();
    clr_cnt = 1'b1; in_valid = 1'b1; in_data = $urandom;
    step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_prio", 64'(word_cnt), 64'd0);
    check("clr_prio4", 64'(word_cnt4), 64'd0);
    step();

    // Random traffic with random backpressure and occasional clears
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom % 2);
      in_data   = $urandom;
      in_chk_en = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      clr_cnt   = ($urandom % 60) == 0;
      step();
    end
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // Reset with two words buffered
    out_ready = 1'b0;
    drive(32'h1234_5678, 1'b1);
    drive(32'h9ABC_DEF0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_word_cnt", 64'(word_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    drive(32'h8000_0000, 1'b1);
    @(negedge clk);
    check("post_rst_data", 64'(out_data), 64'h8000_0000);
    check("post_rst_chk", 64'(out_chk), 64'h88);
    step();

`ifdef ECC_ERR_INJECT_EN
    // One-shot injection on data bit 5
    inj_idx = 6'd5; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    drive(32'h0, 1'b1);
    @(negedge clk);
    check("inj_data", 64'(out_data), 64'h20);
    check("inj_chk", 64'(out_chk), 64'h00);
    check("inj_corrected", 64'(decode(out_data, out_chk)), 64'h0);
    check("inj_pulse", 64'(inj_done), 64'd1);
    step();
    // Out-of-range index leaves the word clean
    inj_idx = 6'd45; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    drive(32'h0, 1'b1);
    @(negedge clk);
    check("noinj_data", 64'(out_data), 64'h0);
    check("noinj_chk", 64'(out_chk), 64'h0);
    step();
    // Sticky injection on a check bit
    inj_idx = 6'd33; inj_sticky = 1'b1; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    for (int n = 0; n < 5; n++) drive($urandom, 1'b1);
    inj_sticky = 1'b0;
    drive($urandom, 1'b1);
    drive($urandom, 1'b1);
    repeat (3) step();
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish at %0t", $time);
    $fatal(1);
  end

endmodule
